// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control, memory handshake and PC-control signals of the PC sequencer.
interface pc_sequencer_if #(parameter int ADDR_WIDTH = 21);
   logic Start, Mem_Ack, Is_Halt, Is_Jump, Is_Branch, Cond_True, Exec_Done, Irq;
   logic [ADDR_WIDTH-1:0] Branch_Target, Dest_Reg;
   logic PC_Clr, PC_Load, PC_Inc, Mem_Req, IR_Load, Exec_En, Halted, Fault, Irq_Ack;
   modport master (
      input  Start, Mem_Ack, Is_Halt, Is_Jump, Is_Branch, Cond_True, Exec_Done, Irq, Branch_Target,
      output PC_Clr, PC_Load, PC_Inc, Dest_Reg, Mem_Req, IR_Load, Exec_En, Halted, Fault, Irq_Ack
   );
   modport slave (
      output Start, Mem_Ack, Is_Halt, Is_Jump, Is_Branch, Cond_True, Exec_Done, Irq, Branch_Target,
      input  PC_Clr, PC_Load, PC_Inc, Dest_Reg, Mem_Req, IR_Load, Exec_En, Halted, Fault, Irq_Ack
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute sequencer that is the sole writer of the PC, with fetch timeout.
// Define PC_IRQ_EN to let INC/LOAD divert to IRQ_VECTOR when Irq is raised.
module pc_sequencer #(
   parameter int ADDR_WIDTH = 21,
   parameter int TIMEOUT = 15,
   parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = 21'h000010
) (
   input logic Clk,
   input logic Rst_N,
   pc_sequencer_if.master bus
);
   typedef enum logic [3:0] {IDLE, CLEAR, FETCH, DECODE, EXEC, INC, LOAD, HALT, FAULT} state_t;
   state_t state, next_state;
   logic [7:0] cnt;
   logic [ADDR_WIDTH-1:0] dest;
   logic irq_q, irq_d;
   always_comb begin
      next_state = state;
      case (state)
         IDLE:   next_state = bus.Start ? CLEAR : IDLE;
         CLEAR:  next_state = FETCH;
         FETCH:  next_state = bus.Mem_Ack ? DECODE : (cnt == 8'(TIMEOUT - 1)) ? FAULT : FETCH;
         DECODE: next_state = bus.Is_Halt ? HALT :
                              (bus.Is_Jump || (bus.Is_Branch && bus.Cond_True)) ? LOAD :
                              bus.Is_Branch ? INC : EXEC;
         EXEC:   next_state = bus.Exec_Done ? INC : EXEC;
         INC:    next_state = FETCH;
         LOAD:   next_state = FETCH;
         HALT:   next_state = bus.Start ? INC : HALT;
         FAULT:  next_state = bus.Start ? CLEAR : FAULT;
         default: next_state = IDLE;
      endcase
   end
   // Irq is captured on the edge entering INC/LOAD so the registered Dest_Reg already holds the vector in the pulse cycle.
`ifdef PC_IRQ_EN
   assign irq_d = bus.Irq && (next_state == INC || next_state == LOAD);
`else
   assign irq_d = 1'b0;
`endif
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         state <= IDLE;
         cnt <= '0;
         dest <= '0;
         irq_q <= 1'b0;
      end else begin
         state <= next_state;
         cnt <= (state == FETCH && next_state == FETCH) ? cnt + 8'd1 : 8'd0;
         irq_q <= irq_d;
         if (irq_d) dest <= IRQ_VECTOR;
         else if (state == DECODE && next_state == LOAD) dest <= bus.Branch_Target;
      end
   end
   assign bus.PC_Clr   = state == CLEAR;
   assign bus.PC_Load  = state == LOAD || (state == INC && irq_q);
   assign bus.PC_Inc   = state == INC && !irq_q;
   assign bus.Dest_Reg = dest;
   assign bus.Mem_Req  = state == FETCH;
   assign bus.IR_Load  = state == FETCH && bus.Mem_Ack;
   assign bus.Exec_En  = state == EXEC;
   assign bus.Halted   = state == HALT;
   assign bus.Fault    = state == FAULT;
   assign bus.Irq_Ack  = irq_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized instruction streams checked against a transaction-level PC model.
module tb_pc_sequencer;
   localparam int AW = 21;
   localparam int TO = 15;
   // Output vector order: PC_Clr PC_Load PC_Inc Mem_Req IR_Load Exec_En Halted Fault Irq_Ack
   localparam logic [8:0] O_IDLE = 9'b000000000, O_CLR = 9'b100000000, O_FET = 9'b000100000,
                          O_FACK = 9'b000110000, O_EXE = 9'b000001000, O_INC = 9'b001000000,
                          O_LD = 9'b010000000, O_HLT = 9'b000000100, O_FLT = 9'b000000010,
                          O_IRQ = 9'b010000001;
   logic Clk = 1'b0;
   logic Rst_N = 1'b0;
   int tests = 0;
   int fails = 0;
   logic [AW-1:0] pc, exp_pc, exp_dest;
   logic [8:0] outs;
   pc_sequencer_if #(.ADDR_WIDTH(AW)) bus ();
   pc_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .IRQ_VECTOR(21'h000010)) dut (.Clk(Clk), .Rst_N(Rst_N), .bus(bus));
   always #5 Clk = ~Clk;
   assign outs = {bus.PC_Clr, bus.PC_Load, bus.PC_Inc, bus.Mem_Req, bus.IR_Load, bus.Exec_En,
                  bus.Halted, bus.Fault, bus.Irq_Ack};
   // Behavioural PC register driven by the sequencer's controls.
   always @(posedge Clk) pc <= bus.PC_Clr ? '0 : bus.PC_Load ? bus.Dest_Reg : bus.PC_Inc ? pc + 1'b1 : pc;
   always @(negedge Clk) begin
      tests++;
      assert ($onehot0({bus.PC_Clr, bus.PC_Load, bus.PC_Inc})) else begin
         fails++;
         $error("FAIL onehot got=%b exp=at most one high", {bus.PC_Clr, bus.PC_Load, bus.PC_Inc});
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input string tag, input logic [8:0] exp);
      #1 chk(tag, 32'(outs), 32'(exp));
      @(negedge Clk);
   endtask
   task automatic noise();
      bus.Start = 1'($urandom);
      bus.Mem_Ack = 1'($urandom);
      bus.Is_Halt = 1'($urandom);
      bus.Is_Jump = 1'($urandom);
      bus.Is_Branch = 1'($urandom);
      bus.Cond_True = 1'($urandom);
      bus.Exec_Done = 1'($urandom);
      bus.Branch_Target = AW'($urandom);
`ifdef PC_IRQ_EN
      bus.Irq = 1'b0;
`else
      bus.Irq = 1'($urandom);
`endif
   endtask
   // kind: 0 alu, 1 jump, 2 taken branch, 3 untaken branch, 4 halt
   task automatic run_instr(input int kind, input int n_wait, input int n_exec, input int n_halt,
                            input logic [AW-1:0] tgt, input bit irq);
      chk("fetch_pc", 32'(pc), 32'(exp_pc));
      chk("dest_hold", 32'(bus.Dest_Reg), 32'(exp_dest));
      for (int i = 0; i < n_wait; i++) begin
         noise(); bus.Mem_Ack = 1'b0; cyc("fetch_wait", O_FET);
      end
      noise(); bus.Mem_Ack = 1'b1; cyc("fetch_ack", O_FACK);
      noise();
      bus.Is_Halt = kind == 4;
      if (kind != 4) bus.Is_Jump = kind == 1;
      if (kind != 4 && kind != 1) bus.Is_Branch = kind == 2 || kind == 3;
      if (kind == 2 || kind == 3) bus.Cond_True = kind == 2;
      bus.Branch_Target = tgt;
      if (irq && kind != 0 && kind != 4) bus.Irq = 1'b1;
      cyc("decode", O_IDLE);
      if (kind == 0) for (int i = 0; i < n_exec; i++) begin
         noise(); bus.Exec_Done = i == n_exec - 1;
         if (irq && i == n_exec - 1) bus.Irq = 1'b1;
         cyc("exec", O_EXE);
      end
      if (kind == 4) begin
         for (int i = 0; i < n_halt; i++) begin
            noise(); bus.Start = 1'b0; cyc("halt", O_HLT);
         end
         noise(); bus.Start = 1'b1; cyc("halt_start", O_HLT);
      end
      noise();
      if (irq) begin
         bus.Irq = 1'b1;
         exp_dest = 21'h000010;
         #1 chk("irq_dest", 32'(bus.Dest_Reg), 32'(exp_dest));
         cyc("irq_pulse", O_IRQ);
         exp_pc = exp_dest;
      end else if (kind == 1 || kind == 2) begin
         exp_dest = tgt;
         #1 chk("load_dest", 32'(bus.Dest_Reg), 32'(exp_dest));
         cyc("load", O_LD);
         exp_pc = tgt;
      end else begin
         cyc("inc", O_INC);
         exp_pc = exp_pc + 1'b1;
      end
   endtask
   initial begin
      noise(); bus.Start = 1'b0;
      #1 chk("rst_outs", 32'(outs), 32'(O_IDLE));
      chk("rst_dest", 32'(bus.Dest_Reg), 0);
      repeat (2) @(negedge Clk);
      Rst_N = 1'b1;
      noise(); bus.Start = 1'b0; cyc("idle", O_IDLE);
      noise(); bus.Start = 1'b1; cyc("idle_start", O_IDLE);
      noise(); cyc("clear", O_CLR);
      exp_pc = '0; exp_dest = '0;
      run_instr(0, 0, 2, 0, '0, 1'b0);
      run_instr(0, 0, 2, 0, '0, 1'b0);
      run_instr(2, 1, 0, 0, 21'h00ABC, 1'b0);
      run_instr(3, 0, 0, 0, 21'h1F0F0, 1'b0);
      run_instr(0, 2, 1, 0, '0, 1'b0);
      run_instr(1, 0, 0, 0, 21'h000007, 1'b0);
      run_instr(4, 0, 0, 10, '0, 1'b0);
      run_instr(3, TO - 1, 0, 0, 21'h00055, 1'b0);
      // Fetch timeout, sticky fault, restart through CLEAR.
      chk("to_pc", 32'(pc), 32'(exp_pc));
      for (int i = 0; i < TO; i++) begin
         noise(); bus.Mem_Ack = 1'b0; cyc("to_wait", O_FET);
      end
      for (int i = 0; i < 4; i++) begin
         noise(); bus.Start = 1'b0; cyc("fault", O_FLT);
      end
      noise(); bus.Start = 1'b1; cyc("fault_start", O_FLT);
      noise(); cyc("fault_clear", O_CLR);
      exp_pc = '0;
      for (int n = 0; n < 40; n++)
         run_instr(int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), AW'($urandom), 1'b0);
`ifdef PC_IRQ_EN
      run_instr(0, 0, 1, 0, '0, 1'b1);
      run_instr(0, 1, 1, 0, '0, 1'b0);
      run_instr(1, 0, 0, 0, 21'h00321, 1'b1);
      run_instr(3, 0, 0, 0, 21'h00321, 1'b0);
`endif
      // Reset in the middle of EXEC aborts with no PC pulse.
      chk("mid_pc", 32'(pc), 32'(exp_pc));
      noise(); bus.Mem_Ack = 1'b1; cyc("mid_fetch", O_FACK);
      noise(); bus.Is_Halt = 1'b0; bus.Is_Jump = 1'b0; bus.Is_Branch = 1'b0; cyc("mid_decode", O_IDLE);
      noise(); bus.Exec_Done = 1'b0; cyc("mid_exec", O_EXE);
      noise(); bus.Exec_Done = 1'b0; Rst_N = 1'b0;
      #1 chk("mid_rst_outs", 32'(outs), 32'(O_IDLE));
      chk("mid_rst_dest", 32'(bus.Dest_Reg), 0);
      @(negedge Clk);
      noise(); bus.Start = 1'b0; Rst_N = 1'b1; cyc("post_rst_idle", O_IDLE);
      noise(); bus.Start = 1'b0; cyc("post_rst_idle2", O_IDLE);
      chk("post_rst_pc", 32'(pc), 32'(exp_pc));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
